// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and sizes for the push-button conditioner
package btn_pkg;

  // Per-button debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned NUM_BTN = 2;
  localparam int unsigned NUM_LED = 6;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: synchronizer, debounce FSM, long-press detect, pulses
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o,
  // Next-state views so the LED register can update in the same cycle as the pulses.
  output logic pressed_nxt_o,
  output logic press_nxt_o,
  output logic long_active_nxt_o
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_done_q, long_done_d;
  logic          pressed_q, pressed_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // FSM, counter, long-press latch and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next-state logic; the counter is cleared on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    pressed_d   = pressed_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          press_d     = 1'b1;
          pressed_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q != LONG_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to low keeps long_done so the long event cannot repeat.
        if (!sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed_o         = pressed_q;
  assign press_pulse_o     = press_q;
  assign release_pulse_o   = release_q;
  assign long_pulse_o      = long_q;
  assign pressed_nxt_o     = pressed_d;
  assign press_nxt_o       = press_d;
  assign long_active_nxt_o = long_done_d & pressed_d;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - two debounced buttons plus registered active-low status LEDs
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] pressed,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_LED-1:0] led_n
);

  logic [NUM_BTN-1:0] pressed_nxt;
  logic [NUM_BTN-1:0] press_nxt;
  logic [NUM_BTN-1:0] long_act_nxt;
  logic [NUM_BTN-1:0] toggle_q, toggle_d;
  logic [NUM_LED-1:0] led_q, led_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_debounce (
      .clk_i            (clk),
      .rst_i            (rst),
      .btn_n_i          (btn_n[g]),
      .pressed_o        (pressed[g]),
      .press_pulse_o    (press_pulse[g]),
      .release_pulse_o  (release_pulse[g]),
      .long_pulse_o     (long_pulse[g]),
      .pressed_nxt_o    (pressed_nxt[g]),
      .press_nxt_o      (press_nxt[g]),
      .long_active_nxt_o(long_act_nxt[g])
    );
  end

  // LED values derived from the buttons' next state so they move with the pulses.
  always_comb begin
    toggle_d = toggle_q ^ press_nxt;
    led_d    = {~(pressed_nxt[0] & pressed_nxt[1]),
                ~(|long_act_nxt),
                ~toggle_d[1],
                ~toggle_d[0],
                ~pressed_nxt};
  end

  // Toggle bits and LED register; all LEDs dark on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= '0;
      led_q    <= '1;
    end else begin
      toggle_q <= toggle_d;
      led_q    <= led_d;
    end
  end

  assign led_n = led_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - self-checking bench for btn_conditioner
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] pressed, press_pulse, release_pulse, long_pulse;
  logic [5:0] led_n;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .led_n        (led_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Behavioural model: run lengths of synced samples decide events.
  logic [1:0] mh1, mh2, ms;
  logic [1:0] m_pressed, m_press, m_release, m_long, m_long_done, m_toggle, m_prev_low;
  logic [5:0] m_led;
  int         m_run[2];
  int         m_lrun[2];

  // Observed DUT pulse history.
  int n_press[2], n_release[2], n_long[2];
  int press_cyc[2], long_cyc[2];

  task automatic model_reset();
    mh1 = 2'b11; mh2 = 2'b11; ms = 2'b11;
    m_pressed = '0; m_press = '0; m_release = '0; m_long = '0;
    m_long_done = '0; m_toggle = '0; m_prev_low = '0;
    m_led = 6'h3f;
    for (int b = 0; b < 2; b++) begin
      m_run[b] = 0;
      m_lrun[b] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    ms = mh2; mh2 = mh1; mh1 = btn_n;
    m_press = '0; m_release = '0; m_long = '0;
    for (int b = 0; b < 2; b++) begin
      if ((~ms[b]) != m_pressed[b]) begin
        m_run[b]++;
        if (m_run[b] == D + 1) begin
          m_run[b] = 0;
          m_pressed[b] = ~ms[b];
          if (m_pressed[b]) begin
            m_press[b] = 1'b1;
            m_long_done[b] = 1'b0;
            m_lrun[b] = 0;
            m_toggle[b] = ~m_toggle[b];
          end else begin
            m_release[b] = 1'b1;
          end
        end
      end else begin
        m_run[b] = 0;
        if (m_pressed[b]) begin
          m_lrun[b] = m_prev_low[b] ? m_lrun[b] + 1 : 0;
          if (m_lrun[b] == L && !m_long_done[b]) begin
            m_long[b] = 1'b1;
            m_long_done[b] = 1'b1;
          end
        end
      end
      m_prev_low[b] = ~ms[b];
    end
    m_led = {~(m_pressed[0] & m_pressed[1]), ~(|(m_long_done & m_pressed)),
             ~m_toggle[1], ~m_toggle[0], ~m_pressed};
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #2;
    checks++;
    if ({pressed, press_pulse, release_pulse, long_pulse, led_n} !==
        {m_pressed, m_press, m_release, m_long, m_led}) begin
      failures++;
      $display("FAIL model_cmp cyc=%0d got p=%b pp=%b rp=%b lp=%b led=%b expected p=%b pp=%b rp=%b lp=%b led=%b",
               cyc, pressed, press_pulse, release_pulse, long_pulse, led_n,
               m_pressed, m_press, m_release, m_long, m_led);
    end
    for (int b = 0; b < 2; b++) begin
      if (press_pulse[b] === 1'b1) begin n_press[b]++; press_cyc[b] = cyc; end
      if (release_pulse[b] === 1'b1) n_release[b]++;
      if (long_pulse[b] === 1'b1) begin n_long[b]++; long_cyc[b] = cyc; end
    end
  endtask

  task automatic hold(input logic [1:0] v, input int n);
    btn_n = v;
    repeat (n) tick();
  endtask

  int st, np0, np1, nr0, nr1, nl0;

  initial begin
    for (int b = 0; b < 2; b++) begin
      n_press[b] = 0; n_release[b] = 0; n_long[b] = 0;
      press_cyc[b] = 0; long_cyc[b] = 0;
    end
    model_reset();
    repeat (3) tick();
    chk("reset_led", int'(led_n), 6'h3f);
    chk("reset_pressed", int'(pressed), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean press on button 0.
    st = cyc; np0 = n_press[0];
    hold(2'b10, 12);
    chk("clean_press_count", n_press[0] - np0, 1);
    chk("clean_press_latency", press_cyc[0] - (st + 1), 6);
    chk("clean_led", int'(led_n), 6'b111010);
    chk("clean_pressed", int'(pressed), 2'b01);
    nr0 = n_release[0];
    hold(2'b11, 10);
    chk("clean_release_count", n_release[0] - nr0, 1);
    chk("clean_release_led", int'(led_n), 6'b111011);

    // Short bounce on button 1.
    np1 = n_press[1]; nr1 = n_release[1];
    hold(2'b01, 3);
    hold(2'b11, 10);
    chk("bounce_press_count", n_press[1] - np1, 0);
    chk("bounce_release_count", n_release[1] - nr1, 0);
    chk("bounce_pressed", int'(pressed[1]), 0);
    chk("bounce_led", int'(led_n), 6'b111011);

    // Long press, then release with a bounce.
    np0 = n_press[0]; nl0 = n_long[0];
    hold(2'b10, 30);
    chk("long_press_count", n_press[0] - np0, 1);
    chk("long_count", n_long[0] - nl0, 1);
    chk("long_latency", long_cyc[0] - press_cyc[0], 16);
    chk("long_led4", int'(led_n[4]), 0);
    chk("long_led", int'(led_n), 6'b101110);
    nr0 = n_release[0];
    hold(2'b11, 2);
    hold(2'b10, 2);
    hold(2'b11, 12);
    chk("long_release_count", n_release[0] - nr0, 1);
    chk("long_no_refire", n_long[0] - nl0, 1);
    chk("long_release_led", int'(led_n), 6'h3f);

    // Both buttons together.
    np0 = n_press[0]; np1 = n_press[1];
    hold(2'b00, 10);
    chk("both_press0", n_press[0] - np0, 1);
    chk("both_press1", n_press[1] - np1, 1);
    chk("both_same_cycle", press_cyc[0], press_cyc[1]);
    chk("both_led", int'(led_n), 6'b010000);
    hold(2'b01, 10);
    chk("one_released_led", int'(led_n), 6'b110001);
    hold(2'b11, 10);
    chk("both_released_led", int'(led_n), 6'b110011);

    // Reset while button 0 is in debounce.
    np0 = n_press[0];
    hold(2'b10, 4);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_led", int'(led_n), 6'h3f);
    chk("midrst_pressed", int'(pressed), 0);
    chk("midrst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    repeat (2) tick();
    chk("midrst_no_press", n_press[0] - np0, 0);
    rst = 1'b0;
    st = cyc;
    repeat (12) tick();
    chk("requal_press_count", n_press[0] - np0, 1);
    chk("requal_latency", press_cyc[0] - (st + 1), 6);
    hold(2'b11, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side conditioner for the board push-buttons. It synchronizes and debounces two raw active-low buttons and turns them into clean levels and single-cycle press, release and long-press events. It also drives the six active-low status LEDs from that clean state. Downstream gate and logic exercises consume `pressed`/`*_pulse` instead of sampling raw pins.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 270000 (10 ms at 27 MHz): stable-sample count required to accept a level change; legal range ≥ 2.
- `LONG_CYCLES`, default 27000000 (1 s): hold time after press acceptance that fires `long_pulse`; must exceed `DEBOUNCE_CYCLES`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_n` in 2: raw buttons, active-low, asynchronous to `clk`.
- `pressed` out 2: debounced level, 1 = held.
- `press_pulse` out 2: one-cycle strobe on accepted press.
- `release_pulse` out 2: one-cycle strobe on accepted release.
- `long_pulse` out 2: one-cycle strobe, at most once per press.
- `led_n` out 6: active-low status LEDs.

## Operation
- Per button: 2-flop synchronizer; the flops reset to 1 (released).
- Per-button FSM with a counter of width `$clog2(LONG_CYCLES+1)`. The counter clears on every state change.
  - IDLE: on synced low -> PRESS_WAIT.
  - PRESS_WAIT:
    - Synced high -> IDLE (bounce). No outputs change.
    - Otherwise count up. At count `DEBOUNCE_CYCLES-1` -> HELD, assert `press_pulse`, set `pressed`, clear `long_done`.
  - HELD:
    - Synced high -> RELEASE_WAIT.
    - Otherwise count, saturating at `LONG_CYCLES-1`. The first time the count reaches `LONG_CYCLES-1` with `long_done`=0, assert `long_pulse` and set `long_done`.
  - RELEASE_WAIT:
    - Synced low -> HELD. The counter clears and `long_done` is kept, so a release bounce never re-fires `long_pulse`.
    - At count `DEBOUNCE_CYCLES-1` -> IDLE, assert `release_pulse`, clear `pressed`.
- `pressed` is 1 in HELD and RELEASE_WAIT.
- LEDs, all registered:
  - `led_n[1:0]` = `~pressed`.
  - `led_n[2]`/`led_n[3]` = inverse of a toggle bit flipped by `press_pulse[0]`/`press_pulse[1]`.
  - `led_n[4]` = low while any `long_done` is set in HELD/RELEASE_WAIT.
  - `led_n[5]` = `~(pressed[0] & pressed[1])`.
- The two buttons are fully independent. Simultaneous events on both produce both pulses in the same cycle.

## Timing
Reset values:
- `pressed`, `press_pulse`, `release_pulse`, `long_pulse` = 0.
- `led_n` = 6'b111111.
- Both toggle bits = 0; both FSMs in IDLE.

Latency:
- `btn_n` stable low from sampling edge k: sync output low after edge k+1, PRESS_WAIT entered at edge k+2, `press_pulse` high in the cycle after edge k+2+`DEBOUNCE_CYCLES`.
- Release is symmetric.
- `long_pulse` fires `LONG_CYCLES` cycles after `press_pulse`.

Pulse and output rules:
- Every pulse is exactly one cycle wide.
- `press_pulse` and `release_pulse` for the same button never coincide.
- `pressed` and the LEDs update in the same cycle as the corresponding pulse.

Boundary conditions:
- Bounce: a low run shorter than `DEBOUNCE_CYCLES`+1 synced samples produces no event.
- Reset mid-operation: `rst` asserted in any state forces the reset values immediately, with no pulse emitted. After `rst` deasserts with the button held, the button is re-qualified from IDLE.

## Structure
- Shared package `btn_pkg`: FSM state encoding (IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3).
- Sub-module `btn_debounce`: one button's synchronizer, FSM, counter, `long_done` and pulse outputs. Instantiated twice.
- Top level: LED toggle bits and the `led_n` register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=16.
- Reset: assert `rst` mid-clock -> all outputs at reset values asynchronously; `led_n`=6'b111111.
- Clean press: `btn_n[0]`=0 held 12 cycles -> `press_pulse[0]` one cycle at cycle 6 after the first sampling edge, `pressed[0]`=1, `led_n`=6'b111010.
- Bounce: `btn_n[1]` low 3 cycles, then high -> no pulses; `pressed[1]`=0; `led_n` unchanged.
- Long press and release:
  - Hold `btn_n[0]` 30 cycles -> exactly one `long_pulse[0]`, 16 cycles after `press_pulse[0]`, and `led_n[4]`=0.
  - Then release with a 2-cycle bounce -> a single `release_pulse[0]`, no second `long_pulse[0]`.
- Both buttons pressed in the same cycle -> both `press_pulse` asserted in the same cycle; `led_n[5]`=0 until the first release.
- Reset during PRESS_WAIT with button still low -> no `press_pulse`; after reset, the press is accepted 6 cycles later.
